// File: rtl/scan_window_sequencer_if.sv
// Window-origin issue and result-retire channel between the scan sequencer
// (master) and the Viola-Jones classifier pipeline (slave).
interface scan_window_sequencer_if;
  logic        win_valid;
  logic        win_ready;
  logic [3:0]  win_level;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        res_valid;
  logic        res_hit;

  modport master (
    output win_valid, win_level, win_row, win_col,
    input  win_ready, res_valid, res_hit
  );

  modport slave (
    input  win_valid, win_level, win_row, win_col,
    output win_ready, res_valid, res_hit
  );
endinterface

// File: rtl/scan_window_sequencer.sv
// Walks all pyramid levels issuing window origins over valid/ready, tracks in-flight
// windows and hits, and reports frame completion. Optional macro: SCAN_LEVEL_MASK_EN.
module scan_window_sequencer #(
  parameter int LEVELS = 9,
  parameter logic [LEVELS-1:0][15:0] LEVEL_WIDTHS =
    {16'd74, 16'd89, 16'd107, 16'd128, 16'd154, 16'd185, 16'd222, 16'd267, 16'd320},
  parameter logic [LEVELS-1:0][15:0] LEVEL_HEIGHTS =
    {16'd56, 16'd67, 16'd80, 16'd96, 16'd116, 16'd139, 16'd167, 16'd200, 16'd240},
  parameter int WIN             = 24,
  parameter int STRIDE          = 1,
  parameter int INT_WAIT        = 10,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        img_rdy,
`ifdef SCAN_LEVEL_MASK_EN
  input  logic [LEVELS-1:0] level_mask,
`endif
  scan_window_sequencer_if.master bus,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] hit_count,
  output logic [31:0] win_count,
  output logic [1:0]  err_flags
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]    level_q, level_d;
  logic [15:0]   row_q, row_d;
  logic [15:0]   col_q, col_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [15:0]   hit_q, hit_d;
  logic [31:0]   wcnt_q, wcnt_d;
  logic [1:0]    err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [LEVELS-1:0] level_en;
  logic [LEVELS-1:0] scannable;

`ifdef SCAN_LEVEL_MASK_EN
  logic [LEVELS-1:0] mask_q;

  // Mask is captured only when a frame is accepted and held for its duration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (state_q == IDLE && img_rdy) begin
      mask_q <= level_mask;
    end
  end

  assign level_en = mask_q;
`else
  assign level_en = '1;
`endif

  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_scannable
    assign scannable[gi] = (LEVEL_WIDTHS[gi]  >= 16'(WIN + 1)) &&
                           (LEVEL_HEIGHTS[gi] >= 16'(WIN + 1)) &&
                           level_en[gi];
  end

  logic [15:0] cur_w, cur_h;
  logic        first_found, next_found;
  logic [3:0]  first_level, next_level;

  // Descending walk so the lowest qualifying level wins; unscannable levels cost no cycles.
  always_comb begin
    cur_w       = '0;
    cur_h       = '0;
    first_found = 1'b0;
    first_level = '0;
    next_found  = 1'b0;
    next_level  = '0;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      if (level_q == 4'(l)) begin
        cur_w = LEVEL_WIDTHS[l];
        cur_h = LEVEL_HEIGHTS[l];
      end
      if (scannable[l]) begin
        first_found = 1'b1;
        first_level = 4'(l);
      end
      if (scannable[l] && (4'(l) > level_q)) begin
        next_found = 1'b1;
        next_level = 4'(l);
      end
    end
  end

  // 17-bit arithmetic keeps col+STRIDE from wrapping near 16'hFFFF.
  logic [16:0] col_step, row_step, col_lim, row_lim;
  logic        last_col, last_row;

  assign col_step = {1'b0, col_q} + 17'(STRIDE);
  assign row_step = {1'b0, row_q} + 17'(STRIDE);
  assign col_lim  = {1'b0, cur_w} - 17'(WIN + 1);
  assign row_lim  = {1'b0, cur_h} - 17'(WIN + 1);
  assign last_col = col_step > col_lim;
  assign last_row = row_step > row_lim;

  logic win_valid_w, xfer, res_ok, res_err;

  assign win_valid_w = (state_q == SCAN) && (outstanding_q < OW'(MAX_OUTSTANDING));
  assign xfer        = win_valid_w && bus.win_ready;
  assign res_ok      = bus.res_valid && (outstanding_q != '0);
  assign res_err     = bus.res_valid && (outstanding_q == '0);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    level_d       = level_q;
    row_d         = row_q;
    col_d         = col_q;
    outstanding_d = outstanding_q;
    hit_d         = hit_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (img_rdy) begin
          state_d    = WAIT;
          wait_cnt_d = 16'd1;
          hit_d      = '0;
          wcnt_d     = '0;
          err_d      = '0;
          busy_d     = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt_q >= 16'(INT_WAIT)) begin
          if (first_found) begin
            state_d = SCAN;
            level_d = first_level;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      SCAN: begin
        if (xfer) begin
          wcnt_d = wcnt_q + 32'd1;
          if (!last_col) begin
            col_d = col_step[15:0];
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_step[15:0];
            end else begin
              row_d = '0;
              if (next_found) level_d = next_level;
              else            state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if ((outstanding_q == '0) && !bus.res_valid) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (img_rdy && (state_q != IDLE)) err_d[0] = 1'b1;
    if (res_err)                      err_d[1] = 1'b1;
    if (res_ok && bus.res_hit && (hit_q != 16'hFFFF)) hit_d = hit_q + 16'd1;

    case ({xfer, res_ok})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      level_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      outstanding_q <= '0;
      hit_q         <= '0;
      wcnt_q        <= '0;
      err_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      level_q       <= level_d;
      row_q         <= row_d;
      col_q         <= col_d;
      outstanding_q <= outstanding_d;
      hit_q         <= hit_d;
      wcnt_q        <= wcnt_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.win_valid = win_valid_w;
  assign bus.win_level = level_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign hit_count     = hit_q;
  assign win_count     = wcnt_q;
  assign err_flags     = err_q;

endmodule

// File: tb/tb_scan_window_sequencer.sv
// Scoreboard bench: DUT A (stride 1, 4 outstanding) and DUT B (stride 2) checked
// against a geometric reference list of window origins.
module tb_scan_window_sequencer;
  localparam logic [1:0][15:0] TW = {16'd26, 16'd30};
  localparam logic [1:0][15:0] TH = {16'd25, 16'd28};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, img_rdy_a, img_rdy_b;
  logic        busy_a, fd_a, busy_b, fd_b;
  logic [15:0] hit_a, hit_b;
  logic [31:0] wc_a, wc_b;
  logic [1:0]  err_a, err_b;

  scan_window_sequencer_if bus_a ();
  scan_window_sequencer_if bus_b ();

  scan_window_sequencer #(
    .LEVELS(2), .LEVEL_WIDTHS(TW), .LEVEL_HEIGHTS(TH), .WIN(24),
    .STRIDE(1), .INT_WAIT(10), .MAX_OUTSTANDING(4)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .img_rdy(img_rdy_a),
`ifdef SCAN_LEVEL_MASK_EN
    .level_mask(2'b11),
`endif
    .bus(bus_a), .busy(busy_a), .frame_done(fd_a), .hit_count(hit_a),
    .win_count(wc_a), .err_flags(err_a)
  );

  scan_window_sequencer #(
    .LEVELS(2), .LEVEL_WIDTHS(TW), .LEVEL_HEIGHTS(TH), .WIN(24),
    .STRIDE(2), .INT_WAIT(10), .MAX_OUTSTANDING(16)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .img_rdy(img_rdy_b),
`ifdef SCAN_LEVEL_MASK_EN
    .level_mask(2'b11),
`endif
    .bus(bus_b), .busy(busy_b), .frame_done(fd_b), .hit_count(hit_b),
    .win_count(wc_b), .err_flags(err_b)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_a[$];
  logic [35:0] exp_b[$];
  int          ret_q[$];
  bit          hitq[$];
  int          cyc = 0;
  int          xfer_a = 0;
  int          issued_b = 0, retired_b = 0, fd_b_cnt = 0;
  bit          rand_ready = 0, hits_en = 0, hold = 0;
  int          extra_req = 0, credit_req = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: every in-bounds origin, col fastest, then row, then level.
  task automatic load_exp(input int stride, input bit to_b);
    int w[2];
    int h[2];
    w = '{30, 26};
    h = '{28, 25};
    for (int lv = 0; lv < 2; lv++)
      if (w[lv] >= 25 && h[lv] >= 25)
        for (int r = 0; r + 25 <= h[lv]; r += stride)
          for (int c = 0; c + 25 <= w[lv]; c += stride)
            if (to_b) exp_b.push_back({4'(lv), 16'(r), 16'(c)});
            else      exp_a.push_back({4'(lv), 16'(r), 16'(c)});
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor A: scores each transfer and schedules its result 3 cycles later.
  initial forever begin
    @(negedge clock);
    if (!reset_n) exp_a.delete();
    if (reset_n && bus_a.win_valid && bus_a.win_ready) begin
      xfer_a++;
      if (exp_a.size() == 0) begin
        chk("window_a_unexpected", 1, 0);
      end else begin
        int idx;
        idx = 26 - exp_a.size();
        chk("window_a", {bus_a.win_level, bus_a.win_row, bus_a.win_col}, exp_a.pop_front());
        ret_q.push_back(cyc + 3);
        hitq.push_back(hits_en && (idx == 5 || idx == 17));
      end
    end
  end

  initial begin
    int extra_done = 0, credit_used = 0;
    bus_a.win_ready = 1'b1;
    bus_a.res_valid = 1'b0;
    bus_a.res_hit   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus_a.win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_a.res_valid = 1'b0;
      bus_a.res_hit   = 1'b0;
      if (!reset_n) begin
        ret_q.delete();
        hitq.delete();
      end else if (extra_req > extra_done) begin
        extra_done++;
        bus_a.res_valid = 1'b1;
      end else if (ret_q.size() > 0 && ret_q[0] <= cyc && (!hold || credit_req > credit_used)) begin
        if (hold) credit_used++;
        bus_a.res_valid = 1'b1;
        bus_a.res_hit   = hitq.pop_front();
        void'(ret_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (!reset_n) exp_b.delete();
    if (fd_b) fd_b_cnt++;
    if (reset_n && bus_b.win_valid && bus_b.win_ready) begin
      issued_b++;
      if (exp_b.size() == 0) chk("window_b_unexpected", 1, 0);
      else chk("window_b", {bus_b.win_level, bus_b.win_row, bus_b.win_col}, exp_b.pop_front());
    end
  end

  initial begin
    bus_b.win_ready = 1'b1;
    bus_b.res_valid = 1'b0;
    bus_b.res_hit   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus_b.res_valid = 1'b0;
      if (issued_b > retired_b) begin
        retired_b++;
        bus_b.res_valid = 1'b1;
      end
    end
  end

  task automatic pulse_a(input bit also_b);
    @(posedge clock);
    #1;
    img_rdy_a = 1'b1;
    img_rdy_b = also_b;
    @(posedge clock);
    #1;
    img_rdy_a = 1'b0;
    img_rdy_b = 1'b0;
  endtask

  task automatic wait_done_a(input int wc, input int hits, input int errv);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (fd_a) break;
    end
    chk("frame_done_seen", fd_a, 1);
    chk("retired_before_done", ret_q.size(), 0);
    chk("all_windows_issued", exp_a.size(), 0);
    @(negedge clock);
    chk("frame_done_single", fd_a, 0);
    chk("busy_after_done", busy_a, 0);
    chk("win_count", wc_a, wc);
    chk("hit_count", hit_a, hits);
    chk("err_flags_at_done", err_a, errv);
  endtask

  initial begin
    int lat, x0;
    reset_n   = 1'b0;
    img_rdy_a = 1'b0;
    img_rdy_b = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_win_valid", bus_a.win_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_origin", {bus_a.win_level, bus_a.win_row, bus_a.win_col}, 0);
    chk("rst_counts", {hit_a, wc_a, err_a}, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Frame 1: always ready, latency 3, no hits; DUT B runs stride 2 alongside.
    load_exp(1, 0);
    load_exp(2, 1);
    pulse_a(1'b1);
    for (lat = 1; lat < 100; lat++) begin
      @(negedge clock);
      if (bus_a.win_valid) break;
      @(posedge clock);
    end
    chk("first_valid_latency", lat, 11);
    wait_done_a(26, 0, 0);
    chk("b_frame_done_pulses", fd_b_cnt, 1);
    chk("b_win_count", wc_b, 7);
    chk("b_all_issued", exp_b.size(), 0);
    chk("b_busy", busy_b, 0);

    // Frame 2: random ready, hits on windows 5 and 17, stray img_rdy, late result.
    rand_ready = 1;
    hits_en    = 1;
    load_exp(1, 0);
    pulse_a(1'b0);
    repeat (30) @(posedge clock);
    chk("busy_mid_scan", busy_a, 1);
    pulse_a(1'b0);
    wait_done_a(26, 2, 1);
    extra_req++;
    repeat (6) @(negedge clock);
    chk("err_flags_sticky", err_a, 3);
    chk("no_restart_busy", busy_a, 0);
    chk("no_restart_count", wc_a, 26);
    chk("hits_held", hit_a, 2);

    // Frame 3: no results returned, so issue must stall at 4 outstanding.
    rand_ready = 0;
    hits_en    = 0;
    hold       = 1;
    load_exp(1, 0);
    x0 = xfer_a;
    pulse_a(1'b0);
    @(negedge clock);
    chk("err_cleared_on_accept", err_a, 0);
    repeat (31) @(negedge clock);
    chk("hold_transfers", xfer_a - x0, 4);
    chk("hold_valid_low", bus_a.win_valid, 0);
    credit_req++;
    repeat (10) @(negedge clock);
    chk("one_more_transfer", xfer_a - x0, 5);
    chk("valid_low_again", bus_a.win_valid, 0);

    // Asynchronous reset mid-frame.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", bus_a.win_valid, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_origin", {bus_a.win_level, bus_a.win_row, bus_a.win_col}, 0);
    chk("async_rst_counts", {hit_a, wc_a, err_a}, 0);
    hold = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Frame 4: clean frame after reset.
    load_exp(1, 0);
    pulse_a(1'b0);
    wait_done_a(26, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_window_sequencer.md
Name: scan_window_sequencer

Overview:
- Parametrised successor to the per-frame window-scan FSM in the face detector.
- Walks every pyramid level and emits integral-image window origins `(level, row, col)` with a configurable stride.
- Uses a valid/ready handshake to the Viola-Jones pipeline, replacing the divided-clock pacing.
- Tracks in-flight windows, counts face hits, and signals frame completion only after every issued window has retired.

Parameters:
- LEVELS, 9, number of pyramid levels (1..15).
- LEVEL_WIDTHS, packed [LEVELS-1:0][15:0], per-level image width in pixels.
- LEVEL_HEIGHTS, packed [LEVELS-1:0][15:0], per-level image height in pixels.
- WIN, 24, window size; each window spans WIN+1 integral samples.
- STRIDE, 1, row and column step in pixels (>=1).
- INT_WAIT, 10, clock cycles from img_rdy until scanning starts (integral-image settle time).
- MAX_OUTSTANDING, 16, maximum windows issued but not yet retired.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  reset.
- img_rdy  in  1  one-cycle pulse: new frame loaded.
- win_valid  out  1  window origin valid.
- win_ready  in  1  pipeline accepts window.
- win_level  out  4  pyramid level of the window.
- win_row  out  16  window origin row.
- win_col  out  16  window origin column.
- res_valid  in  1  pipeline retires one window.
- res_hit  in  1  retired window is a face (qualified by res_valid).
- busy  out  1  high from img_rdy accept until done.
- frame_done  out  1  one-cycle pulse when all windows are retired.
- hit_count  out  16  face hits in current/last frame.
- win_count  out  32  windows issued in current/last frame.
- err_flags  out  2  sticky: [0] img_rdy while busy, [1] res_valid with zero outstanding.

Interface: one clock; reset is asynchronous and active-low. Reset port is `reset_n`; clock port is `clock`.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state IDLE;
  - win_valid, busy, frame_done = 0;
  - win_level, win_row, win_col = 0;
  - hit_count, win_count = 0;
  - err_flags = 0;
  - outstanding = 0.
- Reset mid-frame aborts immediately. Results arriving after reset release are flagged via err_flags[1].
- States:
  - IDLE:
    - img_rdy -> WAIT. Clear hit_count, win_count and err_flags. Set busy.
  - WAIT:
    - Counter runs 1..INT_WAIT.
    - On reaching INT_WAIT -> SCAN at level 0, row 0, col 0.
  - SCAN:
    - Level L is scannable iff LEVEL_WIDTHS[L] >= WIN+1 and LEVEL_HEIGHTS[L] >= WIN+1. Unscannable levels are skipped with zero cycles spent on them.
    - Origins per level: col = 0, STRIDE, ... while col <= W-WIN-1; row likewise against H.
    - Order: col fastest, then row, then level.
    - win_valid is asserted iff outstanding < MAX_OUTSTANDING.
    - A transfer occurs when win_valid && win_ready. On transfer: advance the origin, increment win_count and outstanding.
    - Outputs stay stable while win_valid && !win_ready.
    - After the last origin of the last level transfers -> DRAIN.
  - DRAIN:
    - win_valid = 0.
    - When outstanding == 0 and no res_valid is pending this cycle: pulse frame_done for 1 cycle, drop busy -> IDLE.
    - If no scannable level exists, WAIT goes directly to DRAIN.
- Retire: on res_valid, decrement outstanding and add res_hit to hit_count.
- Simultaneous issue and retire in the same cycle: outstanding is unchanged.
- res_valid while outstanding == 0: ignored, set err_flags[1].
- img_rdy outside IDLE: ignored, set err_flags[0]. No restart.
- Saturation: hit_count saturates at 16'hFFFF.
- Origin advance uses 17-bit compares so col+STRIDE cannot wrap.
- Latency: first win_valid occurs INT_WAIT+1 cycles after the img_rdy cycle.
- hit_count and win_count hold their values after frame_done until the next accepted img_rdy.

Optional Feature:
- SCAN_LEVEL_MASK_EN defined:
  - Adds input port `level_mask [LEVELS-1:0]`, sampled on img_rdy accept and held for the frame.
  - Levels with a 0 bit are treated as unscannable (skipped).
  - A mask of all zeros gives an immediate DRAIN and frame_done with win_count = 0.
- Undefined: no port; all levels are eligible.

Test Plan:
- LEVELS=2, widths {30,26}, heights {28,25}, WIN=24, STRIDE=1, win_ready=1, results returned 3 cycles after issue, no hits:
  -> 24 windows at level 0 (rows 0..3, cols 0..5), then 2 windows at level 1 (row 0, cols 0..1);
  -> win_count = 26; frame_done a single pulse after the last retire; first win_valid 11 cycles after img_rdy.
- Same config, STRIDE=2:
  -> level 0 cols {0,2,4}, rows {0,2} = 6 windows; level 1 col {0}, row {0} = 1 window; win_count = 7.
- MAX_OUTSTANDING=4, no res_valid for 20 cycles:
  -> exactly 4 transfers, then win_valid held 0;
  -> one res_valid -> exactly one more transfer.
- win_ready toggled pseudo-randomly:
  -> origin is unchanged across stalled cycles; sequence is identical to the first test.
- res_hit=1 on windows 5 and 17, img_rdy pulsed again mid-SCAN, extra res_valid after DRAIN completes:
  -> hit_count = 2; err_flags = 2'b11; the second frame is not started.
- reset_n asserted mid-SCAN:
  -> all outputs at reset values on the same edge;
  -> a new img_rdy runs a clean frame with win_count = 26.
